// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage core: load-use bubbles, MDU freeze
// with timeout, and branch-redirect flushes, plus saturating event counters.
module hazard_stall_ctrl #(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memRead,
  input  logic             ex_writeReg,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             ex_redirect,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_me_bubble,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned WW = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;

  typedef enum logic {RUN, MDU_BUSY} state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          lu, tmo, ms, redir, lu_ok;

  always_comb begin
    lu    = ex_memRead & ex_writeReg & (ex_rd != '0) &
            ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    tmo   = (state == MDU_BUSY) & (wait_cnt == WW'(MDU_TIMEOUT - 1));
    ms    = ((state == RUN) & ex_mdu_start & ~mdu_done) |
            ((state == MDU_BUSY) & ~mdu_done & ~tmo);
    redir = (state == RUN) & ex_redirect & ~ms;
    lu_ok = lu & ~ms & ~redir;
  end

  // Outputs are forced low while reset is asserted, independent of the clock.
  always_comb begin
    pc_stall     = rst_n & (ms | lu_ok);
    if_id_stall  = rst_n & (ms | lu_ok);
    if_id_flush  = rst_n & redir;
    id_ex_stall  = rst_n & ms;
    id_ex_flush  = rst_n & (redir | lu_ok);
    ex_me_bubble = rst_n & ms;
    mdu_timeout  = rst_n & tmo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (ex_mdu_start && !mdu_done) begin
            state    <= MDU_BUSY;
            wait_cnt <= '0;
          end
        end
        MDU_BUSY: begin
          if (mdu_done || tmo) state <= RUN;
          else                 wait_cnt <= wait_cnt + 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (redir && (flush_events != '1))    flush_events <= flush_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus random
// stimulus compared against a rule-level reference model.
module tb_hazard_stall_ctrl;

  localparam int unsigned TMO  = 8;
  localparam int unsigned CW   = 4;
  localparam int          MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_memRead, ex_writeReg;
  logic          ex_mdu_start, mdu_done, ex_redirect;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic          ex_me_bubble, mdu_timeout;
  logic [CW-1:0] stall_cycles, flush_events;

  int total = 0;
  int bad   = 0;

  hazard_stall_ctrl #(.MDU_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_memRead(ex_memRead), .ex_writeReg(ex_writeReg), .ex_rd(ex_rd),
    .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done), .ex_redirect(ex_redirect),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_me_bubble(ex_me_bubble),
    .mdu_timeout(mdu_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_me_bubble, mdu_timeout}
  logic [6:0] pins;
  assign pins = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                 ex_me_bubble, mdu_timeout};

  // Reference model: "busy" = an MDU op is outstanding, "elapsed" = busy cycles already spent.
  bit m_busy    = 1'b0;
  int m_elapsed = 0;
  int m_stall   = 0;
  int m_flush   = 0;

  function automatic logic [6:0] exp_pins();
    bit lu, tmo, ms, rd, luo;
    if (rst_n !== 1'b1) return 7'b0;
    lu  = ex_memRead && ex_writeReg && (ex_rd != 0) &&
          ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    tmo = m_busy && (m_elapsed == TMO - 1);
    ms  = m_busy ? (!mdu_done && !tmo) : (ex_mdu_start && !mdu_done);
    rd  = !m_busy && !ms && ex_redirect;
    luo = lu && !ms && !rd;
    return {ms || luo, ms || luo, rd, ms, rd || luo, ms, tmo};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [6:0] p;
    if (!rst_n) begin
      m_busy = 1'b0; m_elapsed = 0; m_stall = 0; m_flush = 0;
    end else begin
      p = exp_pins();
      if (p[6] && m_stall < MAXC) m_stall++;
      if (p[4] && m_flush < MAXC) m_flush++;
      if (!m_busy) begin
        if (ex_mdu_start && !mdu_done) begin m_busy = 1'b1; m_elapsed = 0; end
      end else if (mdu_done || m_elapsed == TMO - 1) m_busy = 1'b0;
      else m_elapsed++;
    end
  end

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_memRead = 0; ex_writeReg = 0; ex_mdu_start = 0; mdu_done = 0; ex_redirect = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    ex_mdu_start = 1; ex_redirect = 1; ex_memRead = 1; ex_writeReg = 1;
    ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1;
    rst_n = 0;
    #22;
    total++; if (pins !== 7'b0) begin bad++; $display("FAIL reset_pins got=%b want=%b", pins, 7'b0); end
    total++; if (stall_cycles !== '0 || flush_events !== '0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_cycles, flush_events); end
    @(negedge clk); idle(); rst_n = 1;
    next_cycle();
  endtask

  task automatic test_load_use();
    int base = m_stall;
    idle(); ex_memRead = 1; ex_writeReg = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1; #2;
    total++; if (pins !== 7'b1100100) begin bad++; $display("FAIL lu_hit got=%b want=%b", pins, 7'b1100100); end
    next_cycle();
    ex_memRead = 0; #2;
    total++; if (pins !== 7'b0) begin bad++; $display("FAIL lu_after_bubble got=%b want=%b", pins, 7'b0); end
    total++; if (int'(stall_cycles) !== base + 1) begin
      bad++; $display("FAIL lu_count got=%0d want=%0d", stall_cycles, base + 1); end
    idle(); ex_memRead = 1; ex_writeReg = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1; #2;
    total++; if (pins !== 7'b0) begin bad++; $display("FAIL lu_x0 got=%b want=%b", pins, 7'b0); end
    idle(); ex_memRead = 1; ex_writeReg = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 0; #2;
    total++; if (pins !== 7'b0) begin bad++; $display("FAIL lu_rs2_unused got=%b want=%b", pins, 7'b0); end
    idle(); next_cycle();
  endtask

  task automatic test_mdu();
    int base = m_stall;
    for (int i = 0; i < 5; i++) begin
      idle(); ex_mdu_start = (i == 0); mdu_done = (i == 4); #2;
      total++;
      if (pins !== ((i < 4) ? 7'b1101010 : 7'b0)) begin
        bad++; $display("FAIL mdu_cycle%0d got=%b want=%b", i, pins, (i < 4) ? 7'b1101010 : 7'b0); end
      next_cycle();
    end
    idle(); #2;
    total++; if (int'(stall_cycles) !== base + 4) begin
      bad++; $display("FAIL mdu_count got=%0d want=%0d", stall_cycles, base + 4); end
    ex_mdu_start = 1; mdu_done = 1; #2;
    total++; if (pins !== 7'b0) begin bad++; $display("FAIL mdu_same_cycle got=%b want=%b", pins, 7'b0); end
    next_cycle();
    idle(); ex_redirect = 1; #2;
    total++; if (pins !== 7'b0010100) begin
      bad++; $display("FAIL mdu_same_cycle_run got=%b want=%b", pins, 7'b0010100); end
    next_cycle(); idle();
  endtask

  task automatic test_redirect();
    int base = m_flush;
    idle(); ex_redirect = 1; ex_memRead = 1; ex_writeReg = 1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1; #2;
    total++; if (pins !== 7'b0010100) begin bad++; $display("FAIL redirect_over_lu got=%b want=%b", pins, 7'b0010100); end
    next_cycle(); idle(); #2;
    total++; if (int'(flush_events) !== base + 1) begin
      bad++; $display("FAIL redirect_count got=%0d want=%0d", flush_events, base + 1); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 10; i++) begin
      idle(); ex_mdu_start = (i == 0); ex_redirect = (i == 3); #2;
      total++;
      if (pins !== ((i < 8) ? 7'b1101010 : (i == 8) ? 7'b0000001 : 7'b0)) begin
        bad++; $display("FAIL timeout_cycle%0d got=%b want=%b", i, pins,
                        (i < 8) ? 7'b1101010 : (i == 8) ? 7'b0000001 : 7'b0); end
      next_cycle();
    end
    idle(); ex_mdu_start = 1; next_cycle(); idle(); next_cycle(); next_cycle(); #2;
    rst_n = 0; #1;
    total++; if (pins !== 7'b0) begin bad++; $display("FAIL reset_mid_wait got=%b want=%b", pins, 7'b0); end
    total++; if (stall_cycles !== '0 || flush_events !== '0) begin
      bad++; $display("FAIL reset_mid_wait_cnt got=%0d/%0d want=0/0", stall_cycles, flush_events); end
    @(negedge clk); rst_n = 1; next_cycle();
  endtask

  task automatic test_saturation();
    idle(); ex_memRead = 1; ex_writeReg = 1; ex_rd = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1;
    for (int i = 0; i < 20; i++) next_cycle();
    #2;
    total++; if (int'(stall_cycles) !== MAXC) begin
      bad++; $display("FAIL stall_saturate got=%0d want=%0d", stall_cycles, MAXC); end
    idle(); ex_redirect = 1;
    for (int i = 0; i < 20; i++) next_cycle();
    #2;
    total++; if (int'(flush_events) !== MAXC) begin
      bad++; $display("FAIL flush_saturate got=%0d want=%0d", flush_events, MAXC); end
    idle(); rst_n = 0; #1; @(negedge clk); rst_n = 1; next_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ex_rd        = 5'($urandom_range(0, 3));
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      ex_memRead   = 1'($urandom_range(0, 1));
      ex_writeReg  = 1'($urandom_range(0, 3) != 0);
      ex_mdu_start = ($urandom_range(0, 4) == 0);
      mdu_done     = ($urandom_range(0, 9) == 0);
      ex_redirect  = ($urandom_range(0, 5) == 0);
      #2;
      total++; if (pins !== exp_pins()) begin
        bad++; $display("FAIL rand_pins cyc=%0d got=%b want=%b", i, pins, exp_pins()); end
      total++; if (int'(stall_cycles) !== m_stall || int'(flush_events) !== m_flush) begin
        bad++; $display("FAIL rand_counters cyc=%0d got=%0d/%0d want=%0d/%0d",
                        i, stall_cycles, flush_events, m_stall, m_flush); end
      next_cycle();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_mdu();
    test_redirect();
    test_timeout();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
